// File: rtl/bus6502_pkg.sv
// Shared definitions for the 6502 bus memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus6502_pkg;

  // Polarity of the CPU rw line.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Width of the wait-state counter (0..15 stall cycles).
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } bus_state_t;

endpackage

// File: rtl/bus6502_ram.sv
// Single-write-port register array; the bus write takes the port over a load write.
// Latency: write at the clock edge, read is asynchronous (same cycle).
// Backpressure: none; callers arbitrate so at most one writer is active per edge.
//
// Ports: clk; bus_we/bus_addr/bus_wdata (CPU write); ld_we/ld_addr/ld_wdata
// (side-band preload); rd_addr/rd_data (asynchronous read).
module bus6502_ram #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  bus_we,
  input  logic [DEPTH_LOG2-1:0] bus_addr,
  input  logic [DATA_W-1:0]     bus_wdata,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_wdata,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic                  we;
  logic [DEPTH_LOG2-1:0] wa;
  logic [DATA_W-1:0]     wd;

  always_comb begin
    we = bus_we | ld_we;
    if (bus_we) begin
      wa = bus_addr;
      wd = bus_wdata;
    end else begin
      wa = ld_addr;
      wd = ld_wdata;
    end
  end

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_mem6502.sv
// Memory responder for the 6502 bus: window decode, wait states, read drive, write capture, preload.
// Latency: WAIT_STATES+1 cycles from the address edge to the data/write-commit edge; preload commits in one edge.
// Backpressure: rdy=0 stalls the CPU during wait states; a load is refused while the bus hits or is busy.
//
// Ports: clk, reset (async, active-high); addr, data (inout), rw = CPU bus;
// rdy = stall, sel = combinational window hit; ld_en/ld_addr/ld_data/ld_ack =
// preload port; wr_count = committed bus writes (wraps).
module bus_mem6502
  import bus6502_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH_LOG2  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0,
  parameter bit                WRITE_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     addr,
  inout  wire  [DATA_W-1:0]     data,
  input  logic                  rw,
  output logic                  rdy,
  output logic                  sel,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  output logic                  ld_ack,
  output logic [15:0]           wr_count
);

  localparam logic [ADDR_W:0]     WIN_SIZE = {{ADDR_W{1'b0}}, 1'b1} << DEPTH_LOG2;
  localparam logic [WAIT_W-1:0]   WS       = WAIT_W'(WAIT_STATES);

  bus_state_t            state;
  logic [WAIT_W-1:0]     cnt;
  logic [DEPTH_LOG2-1:0] lat_off;
  logic                  lat_rw;
  logic [ADDR_W-1:0]     lat_addr;
  logic                  oe_q;

  logic [ADDR_W-1:0]     diff;
  logic [DEPTH_LOG2-1:0] offset;
  logic                  start;
  logic                  bus_we;
  logic                  ld_commit;
  logic [DATA_W-1:0]     rd_data;

  // Unsigned wrap-around subtraction makes one compare cover both window edges.
  assign diff   = addr - BASE_ADDR;
  assign sel    = ({1'b0, diff} < WIN_SIZE);
  assign offset = diff[DEPTH_LOG2-1:0];

  // A new access begins on any hit from IDLE, or on a hit with a different
  // address while busy (abort out of WAIT, back-to-back out of ACK).
  assign start = sel && ((state == IDLE) || (addr != lat_addr));

  assign bus_we    = (state == ACK) && (lat_rw == RW_WRITE) && (rw == RW_WRITE) && WRITE_EN;
  assign ld_commit = ld_en && (state == IDLE) && !sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_off  <= '0;
      lat_rw   <= RW_READ;
      lat_addr <= '0;
      rdy      <= 1'b1;
      oe_q     <= 1'b0;
    end else if (start) begin
      lat_off  <= offset;
      lat_rw   <= rw;
      lat_addr <= addr;
      cnt      <= WS;
      if (WS != '0) begin
        state <= WAIT;
        rdy   <= 1'b0;
        oe_q  <= 1'b0;
      end else begin
        state <= ACK;
        rdy   <= 1'b1;
        oe_q  <= (rw == RW_READ);
      end
    end else begin
      unique case (state)
        WAIT: begin
          if (addr != lat_addr) begin
            // Address moved out of the window mid-stall: drop the access.
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
            oe_q  <= 1'b0;
          end else if (cnt == WAIT_W'(1)) begin
            state <= ACK;
            cnt   <= '0;
            rdy   <= 1'b1;
            oe_q  <= (lat_rw == RW_READ);
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          rdy   <= 1'b1;
          oe_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_ack   <= 1'b0;
      wr_count <= '0;
    end else begin
      ld_ack <= ld_commit;
      if (bus_we) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  bus6502_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .bus_we    (bus_we),
    .bus_addr  (lat_off),
    .bus_wdata (data),
    .ld_we     (ld_commit),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_data),
    .rd_addr   (lat_off),
    .rd_data   (rd_data)
  );

  // The registered enable is qualified by live sel/rw so the driver lets go
  // as soon as the CPU moves the address or turns the bus around.
  assign data = (oe_q && (rw == RW_READ) && sel) ? rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_mem6502.sv
// Directed bench for bus_mem6502: three instances cover zero-wait RAM,
// two-wait ROM and a three-wait RAM windowed at 0x8000.
// When the DUT must be off the bus, the bench drives 0x00 as a probe value.
module tb_bus_mem6502;

  logic clk;
  logic reset;

  logic [15:0] addr_a, addr_b, addr_c;
  logic        rw_a, rw_b, rw_c;
  logic        rdy_a, rdy_b, rdy_c;
  logic        sel_a, sel_b, sel_c;
  logic        ld_en_a, ld_en_b, ld_en_c;
  logic [9:0]  ld_addr_a, ld_addr_b, ld_addr_c;
  logic [7:0]  ld_data_a, ld_data_b, ld_data_c;
  logic        ld_ack_a, ld_ack_b, ld_ack_c;
  logic [15:0] wr_count_a, wr_count_b, wr_count_c;
  wire  [7:0]  data_a, data_b, data_c;
  logic [7:0]  drv_a, drv_b, drv_c;
  logic        drv_en_a, drv_en_b, drv_en_c;

  int vectors;
  int miscompares;

  assign data_a = drv_en_a ? drv_a : 8'bz;
  assign data_b = drv_en_b ? drv_b : 8'bz;
  assign data_c = drv_en_c ? drv_c : 8'bz;

  bus_mem6502 #(.WAIT_STATES(0), .WRITE_EN(1'b1), .BASE_ADDR(16'h0000)) dut_a (
    .clk(clk), .reset(reset), .addr(addr_a), .data(data_a), .rw(rw_a),
    .rdy(rdy_a), .sel(sel_a), .ld_en(ld_en_a), .ld_addr(ld_addr_a),
    .ld_data(ld_data_a), .ld_ack(ld_ack_a), .wr_count(wr_count_a)
  );

  bus_mem6502 #(.WAIT_STATES(2), .WRITE_EN(1'b0), .BASE_ADDR(16'h0000)) dut_b (
    .clk(clk), .reset(reset), .addr(addr_b), .data(data_b), .rw(rw_b),
    .rdy(rdy_b), .sel(sel_b), .ld_en(ld_en_b), .ld_addr(ld_addr_b),
    .ld_data(ld_data_b), .ld_ack(ld_ack_b), .wr_count(wr_count_b)
  );

  bus_mem6502 #(.WAIT_STATES(3), .WRITE_EN(1'b1), .BASE_ADDR(16'h8000)) dut_c (
    .clk(clk), .reset(reset), .addr(addr_c), .data(data_c), .rw(rw_c),
    .rdy(rdy_c), .sel(sel_c), .ld_en(ld_en_c), .ld_addr(ld_addr_c),
    .ld_data(ld_data_c), .ld_ack(ld_ack_c), .wr_count(wr_count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and drive just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    addr_a = 16'hF000; addr_b = 16'hF000; addr_c = 16'h1234;
    rw_a = 1'b1; rw_b = 1'b1; rw_c = 1'b1;
    ld_en_a = 1'b0; ld_en_b = 1'b0; ld_en_c = 1'b0;
    ld_addr_a = '0; ld_addr_b = '0; ld_addr_c = '0;
    ld_data_a = '0; ld_data_b = '0; ld_data_c = '0;
    drv_a = '0; drv_b = '0; drv_c = '0;
    drv_en_a = 1'b0; drv_en_b = 1'b0; drv_en_c = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy_a), 32'd1);
    check("rst_ld_ack", 32'(ld_ack_a), 32'd0);
    check("rst_wr_count", 32'(wr_count_a), 32'd0);
    cyc();
    reset = 1'b0;

    // Zero-wait read after preload
    cyc(); ld_en_a = 1'b1; ld_addr_a = 10'h234; ld_data_a = 8'hAD;
    cyc(); ld_en_a = 1'b0;
    @(negedge clk); check("a_ld_ack_pulse", 32'(ld_ack_a), 32'd1);
    cyc(); addr_a = 16'h0234; rw_a = 1'b1;
    @(negedge clk);
    check("a_ld_ack_once", 32'(ld_ack_a), 32'd0);
    check("a_sel_hit", 32'(sel_a), 32'd1);
    cyc();
    @(negedge clk);
    check("a_read0_data", 32'(data_a), 32'hAD);
    check("a_read0_rdy", 32'(rdy_a), 32'd1);
    cyc(); addr_a = 16'hF000;

    // Write then read back
    cyc(); addr_a = 16'h0020; rw_a = 1'b0; drv_en_a = 1'b1; drv_a = 8'h55;
    cyc();
    cyc(); addr_a = 16'hF000; rw_a = 1'b1; drv_en_a = 1'b0;
    @(negedge clk); check("a_wr_count1", 32'(wr_count_a), 32'd1);
    cyc(); addr_a = 16'h0020;
    cyc();
    @(negedge clk); check("a_readback", 32'(data_a), 32'h55);
    cyc(); addr_a = 16'hF000;
    @(negedge clk); check("a_wr_count_read", 32'(wr_count_a), 32'd1);

    // Load vs bus collision
    cyc(); addr_a = 16'h0020; rw_a = 1'b0; drv_en_a = 1'b1; drv_a = 8'h77;
    ld_en_a = 1'b1; ld_addr_a = 10'h021; ld_data_a = 8'h99;
    cyc();
    @(negedge clk); check("a_ld_refused_hit", 32'(ld_ack_a), 32'd0);
    cyc(); addr_a = 16'hF000; rw_a = 1'b1; drv_en_a = 1'b0;
    @(negedge clk);
    check("a_ld_refused_ack", 32'(ld_ack_a), 32'd0);
    check("a_wr_count2", 32'(wr_count_a), 32'd2);
    cyc(); ld_en_a = 1'b0;
    @(negedge clk); check("a_ld_commit", 32'(ld_ack_a), 32'd1);
    cyc(); addr_a = 16'h0020;
    @(negedge clk); check("a_ld_ack_drop", 32'(ld_ack_a), 32'd0);
    // Back-to-back reads 0x20 then 0x21, one per cycle
    cyc(); addr_a = 16'h0021;
    @(negedge clk); check("a_b2b_first", 32'(data_a), 32'h77);
    cyc();
    @(negedge clk); check("a_b2b_second", 32'(data_a), 32'h99);
    // Turning rw around releases the bus at once
    rw_a = 1'b0; drv_en_a = 1'b1; drv_a = 8'h00;
    #1 check("a_release_on_rw", 32'(data_a), 32'h00);
    cyc(); addr_a = 16'hF000; rw_a = 1'b1; drv_en_a = 1'b0;
    @(negedge clk); check("a_no_write_on_rd", 32'(wr_count_a), 32'd2);

    // Two-wait read
    cyc(); ld_en_b = 1'b1; ld_addr_b = 10'h010; ld_data_b = 8'h12;
    cyc(); ld_en_b = 1'b0; addr_b = 16'h0010; rw_b = 1'b1;
    @(negedge clk);
    check("b_ld_ack", 32'(ld_ack_b), 32'd1);
    check("b_rdy_before", 32'(rdy_b), 32'd1);
    check("b_sel", 32'(sel_b), 32'd1);
    cyc(); @(negedge clk); check("b_rdy_stall1", 32'(rdy_b), 32'd0);
    cyc(); @(negedge clk); check("b_rdy_stall2", 32'(rdy_b), 32'd0);
    cyc(); @(negedge clk);
    check("b_rdy_ack", 32'(rdy_b), 32'd1);
    check("b_wait_data", 32'(data_b), 32'h12);
    cyc(); addr_b = 16'hF000;

    // Write to ROM is ignored
    cyc(); addr_b = 16'h0010; rw_b = 1'b0; drv_en_b = 1'b1; drv_b = 8'h5A;
    repeat (4) cyc();
    addr_b = 16'hF000; rw_b = 1'b1; drv_en_b = 1'b0;
    @(negedge clk); check("b_rom_wr_count", 32'(wr_count_b), 32'd0);
    cyc(); addr_b = 16'h0010;
    repeat (3) cyc();
    @(negedge clk); check("b_rom_old_value", 32'(data_b), 32'h12);
    cyc(); addr_b = 16'hF000;

    // Out of window at BASE 0x8000
    cyc(); addr_c = 16'h1234; rw_c = 1'b1; drv_en_c = 1'b1; drv_c = 8'h00;
    cyc();
    @(negedge clk);
    check("c_oow_sel", 32'(sel_c), 32'd0);
    check("c_oow_rdy", 32'(rdy_c), 32'd1);
    check("c_oow_data", 32'(data_c), 32'h00);
    cyc(); rw_c = 1'b0; drv_c = 8'h3C;
    repeat (5) cyc();
    @(negedge clk);
    check("c_oow_no_write", 32'(wr_count_c), 32'd0);
    check("c_oow_rdy_wr", 32'(rdy_c), 32'd1);
    cyc(); rw_c = 1'b1; drv_en_c = 1'b0;

    // Reset in the middle of a three-wait read
    cyc(); ld_en_c = 1'b1; ld_addr_c = 10'h010; ld_data_c = 8'h6B;
    cyc(); ld_en_c = 1'b0; addr_c = 16'h8010;
    @(negedge clk); check("c_ld_ack", 32'(ld_ack_c), 32'd1);
    cyc(); @(negedge clk); check("c_rdy_stall", 32'(rdy_c), 32'd0);
    cyc(); @(negedge clk);
    reset = 1'b1; drv_en_c = 1'b1; drv_c = 8'h00;
    #1;
    check("c_rst_rdy", 32'(rdy_c), 32'd1);
    check("c_rst_data", 32'(data_c), 32'h00);
    check("a_rst_wr_count", 32'(wr_count_a), 32'd0);
    cyc(); reset = 1'b0; drv_en_c = 1'b0;
    cyc(); @(negedge clk); check("c_reread_stall", 32'(rdy_c), 32'd0);
    repeat (3) cyc();
    @(negedge clk);
    check("c_reread_data", 32'(data_c), 32'h6B);
    check("c_reread_rdy", 32'(rdy_c), 32'd1);
    cyc(); addr_c = 16'h1234;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
